// File: rtl/resize_pkg.sv
// rtl/resize_pkg.sv - shared widths, weight unit and FSM state for the resize datapath
package resize_pkg;
  localparam int COORD_W = 16;
  localparam int FRAC_W  = 12;
  localparam int ACC_W   = COORD_W + FRAC_W;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1 << FRAC_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/resize_coord_axis.sv
// rtl/resize_coord_axis.sv - one axis: saturating position accumulator, edge clamp, weight split
module resize_coord_axis
  import resize_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  input  logic [COORD_W-1:0] step,
  input  logic [COORD_W-1:0] src,
  output logic [COORD_W-1:0] c0,
  output logic [COORD_W-1:0] c1,
  output logic [COORD_W-1:0] w0,
  output logic [COORD_W-1:0] w1
);
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W:0]     sum;
  logic [COORD_W-1:0] ipart;
  logic [COORD_W-1:0] last;
  logic [FRAC_W-1:0]  fpart;
  logic               clamp;

  always_comb begin
    sum     = {1'b0, acc} + {{(ACC_W + 1 - COORD_W){1'b0}}, step};
    acc_nxt = acc;
    if (clr)
      acc_nxt = '0;
    else if (adv)
      acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else
      acc <= acc_nxt;
  end

  // Coordinates describe acc_nxt so the parent can register them alongside the counters.
  assign ipart = acc_nxt[ACC_W-1:FRAC_W];
  assign last  = src - 1'b1;
  assign clamp = (ipart >= last);
  assign fpart = clamp ? '0 : acc_nxt[FRAC_W-1:0];
  assign c0    = clamp ? last : ipart;
  assign c1    = clamp ? last : ipart + 1'b1;
  assign w1    = {{(COORD_W - FRAC_W){1'b0}}, fpart};
  assign w0    = ONE - w1;
endmodule

// File: rtl/resize_coord_gen.sv
// rtl/resize_coord_gen.sv - raster-order bilinear source coordinate and weight generator
module resize_coord_gen
  import resize_pkg::*;
(
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  input  logic [COORD_W-1:0] cfg_src_w,
  input  logic [COORD_W-1:0] cfg_src_h,
  input  logic [COORD_W-1:0] cfg_dst_w,
  input  logic [COORD_W-1:0] cfg_dst_h,
  input  logic [COORD_W-1:0] cfg_step_x,
  input  logic [COORD_W-1:0] cfg_step_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x0,
  output logic [COORD_W-1:0] out_x1,
  output logic [COORD_W-1:0] out_y0,
  output logic [COORD_W-1:0] out_y1,
  output logic [COORD_W-1:0] out_wx0,
  output logic [COORD_W-1:0] out_wx1,
  output logic [COORD_W-1:0] out_wy0,
  output logic [COORD_W-1:0] out_wy1,
  output logic               out_eol,
  output logic               out_eof
);
  state_t             state, state_nxt;
  logic               accept, load, adv_beat, hs;
  logic [COORD_W-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q, step_x_q, step_y_q;
  logic [COORD_W-1:0] ox, oy, ox_nxt, oy_nxt;
  logic [COORD_W-1:0] src_w_sel, src_h_sel, dst_w_sel, dst_h_sel;
  logic [COORD_W-1:0] x0, x1, wx0, wx1, y0, y1, wy0, wy1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Abort takes priority over a handshake on the same cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    adv_beat  = 1'b0;
    hs        = (state == RUN) && out_ready && !abort;
    case (state)
      IDLE: if (start) begin
        accept = 1'b1;
        if (cfg_dst_w == '0 || cfg_dst_h == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (abort)
          state_nxt = IDLE;
        else if (hs && out_eof)
          state_nxt = DONE;
        else if (hs)
          adv_beat = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == RUN);

  assign src_w_sel = accept ? cfg_src_w : src_w_q;
  assign src_h_sel = accept ? cfg_src_h : src_h_q;
  assign dst_w_sel = accept ? cfg_dst_w : dst_w_q;
  assign dst_h_sel = accept ? cfg_dst_h : dst_h_q;

  assign ox_nxt = load ? '0 : (adv_beat ? (out_eol ? '0 : ox + 1'b1) : ox);
  assign oy_nxt = load ? '0 : ((adv_beat && out_eol) ? oy + 1'b1 : oy);

  resize_coord_axis u_axis_x (
    .clk(ap_clk), .rst_n(ap_rst_n),
    .clr(load | (adv_beat & out_eol)), .adv(adv_beat & ~out_eol),
    .step(step_x_q), .src(src_w_sel),
    .c0(x0), .c1(x1), .w0(wx0), .w1(wx1)
  );

  resize_coord_axis u_axis_y (
    .clk(ap_clk), .rst_n(ap_rst_n),
    .clr(load), .adv(adv_beat & out_eol),
    .step(step_y_q), .src(src_h_sel),
    .c0(y0), .c1(y1), .w0(wy0), .w1(wy1)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      src_w_q <= '0; src_h_q <= '0; dst_w_q <= '0; dst_h_q <= '0;
      step_x_q <= '0; step_y_q <= '0;
      ox <= '0; oy <= '0;
      out_x0 <= '0; out_x1 <= '0; out_y0 <= '0; out_y1 <= '0;
      out_wx0 <= '0; out_wx1 <= '0; out_wy0 <= '0; out_wy1 <= '0;
      out_eol <= 1'b0; out_eof <= 1'b0;
    end else begin
      if (accept) begin
        src_w_q  <= cfg_src_w;  src_h_q  <= cfg_src_h;
        dst_w_q  <= cfg_dst_w;  dst_h_q  <= cfg_dst_h;
        step_x_q <= cfg_step_x; step_y_q <= cfg_step_y;
      end
      ox <= ox_nxt;
      oy <= oy_nxt;
      if (load || adv_beat) begin
        out_x0  <= x0;  out_x1  <= x1;  out_y0  <= y0;  out_y1  <= y1;
        out_wx0 <= wx0; out_wx1 <= wx1; out_wy0 <= wy0; out_wy1 <= wy1;
        out_eol <= (ox_nxt == dst_w_sel - 1'b1);
        out_eof <= (ox_nxt == dst_w_sel - 1'b1) && (oy_nxt == dst_h_sel - 1'b1);
      end
    end
  end
endmodule

// File: tb/tb_resize_coord_gen.sv
// tb/tb_resize_coord_gen.sv - self-checking bench for resize_coord_gen
module tb_resize_coord_gen;
  import resize_pkg::*;

  typedef struct packed {
    logic [15:0] x0, x1, y0, y1, wx0, wx1, wy0, wy1;
    logic        eol, eof;
  } beat_t;

  logic        ap_clk = 1'b0, ap_rst_n = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic        busy, done, out_valid, out_eol, out_eof;
  logic [15:0] cfg_src_w = 0, cfg_src_h = 0, cfg_dst_w = 0, cfg_dst_h = 0;
  logic [15:0] cfg_step_x = 0, cfg_step_y = 0;
  logic [15:0] out_x0, out_x1, out_y0, out_y1, out_wx0, out_wx1, out_wy0, out_wy1;

  int    checks = 0, failures = 0;
  int    cyc = 0, hs_count = 0, done_cnt = 0, done_cyc = -1, eof_cyc = -1, valid_cnt = 0;
  int    stall_n = 0;
  bit    mon_en = 1'b0, stall_prev = 1'b0;
  beat_t expq[$];
  beat_t log_q[$];
  beat_t cur, held, exp_b;

  resize_coord_gen dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .cfg_src_w(cfg_src_w), .cfg_src_h(cfg_src_h), .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h),
    .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x0(out_x0), .out_x1(out_x1), .out_y0(out_y0), .out_y1(out_y1),
    .out_wx0(out_wx0), .out_wx1(out_wx1), .out_wy0(out_wy0), .out_wy1(out_wy1),
    .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Position of output pixel o in source space is o*step, saturated to the accumulator range.
  function automatic void axis_model(input int o, input int step, input int src,
                                     output int c0, output int c1, output int w0, output int w1);
    longint acc;
    int     i, f;
    acc = longint'(o) * longint'(step);
    if (acc > 64'd268435455) acc = 64'd268435455;
    i = int'(acc / 4096);
    f = int'(acc % 4096);
    if (i >= src - 1) begin
      c0 = src - 1; c1 = src - 1; f = 0;
    end else begin
      c0 = i; c1 = i + 1;
    end
    w1 = f;
    w0 = 4096 - f;
  endfunction

  task automatic push_frame(input int sw, input int sh, input int dw, input int dh,
                            input int sx, input int sy);
    beat_t b;
    int    c0, c1, w0, w1;
    for (int y = 0; y < dh; y++)
      for (int x = 0; x < dw; x++) begin
        axis_model(x, sx, sw, c0, c1, w0, w1);
        b.x0 = c0[15:0]; b.x1 = c1[15:0]; b.wx0 = w0[15:0]; b.wx1 = w1[15:0];
        axis_model(y, sy, sh, c0, c1, w0, w1);
        b.y0 = c0[15:0]; b.y1 = c1[15:0]; b.wy0 = w0[15:0]; b.wy1 = w1[15:0];
        b.eol = (x == dw - 1);
        b.eof = (x == dw - 1) && (y == dh - 1);
        expq.push_back(b);
      end
  endtask

  task automatic cmp_beat(input beat_t a, input beat_t e);
    chk("beat_x0", a.x0, e.x0);   chk("beat_x1", a.x1, e.x1);
    chk("beat_y0", a.y0, e.y0);   chk("beat_y1", a.y1, e.y1);
    chk("beat_wx0", a.wx0, e.wx0); chk("beat_wx1", a.wx1, e.wx1);
    chk("beat_wy0", a.wy0, e.wy0); chk("beat_wy1", a.wy1, e.wy1);
    chk("beat_eol", a.eol, e.eol); chk("beat_eof", a.eof, e.eof);
  endtask

  always @(negedge ap_clk) begin
    if (mon_en) begin
      cur = {out_x0, out_x1, out_y0, out_y1, out_wx0, out_wx1, out_wy0, out_wy1, out_eol, out_eof};
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", int'(cur == held), 1);
      end
      if (out_valid && out_ready && !abort) begin
        hs_count++;
        log_q.push_back(cur);
        if (out_eof) eof_cyc = cyc;
        if (expq.size() == 0) chk("extra_beat", 1, 0);
        else begin
          exp_b = expq.pop_front();
          cmp_beat(cur, exp_b);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = cur;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (out_valid) valid_cnt++;
    end
  end

  task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                           input int sx, input int sy, input int stall_at, input int stall_len,
                           input int abort_at, input int rst_at, input bit junk);
    bit aborted = 0, rst_hit = 0, junk_done = 0, timed_out = 1;
    push_frame(sw, sh, dw, dh, sx, sy);
    hs_count = 0; done_cnt = 0; done_cyc = -1; eof_cyc = -1; stall_n = 0;
    log_q.delete();
    @(posedge ap_clk); #1;
    cfg_src_w = 16'(sw); cfg_src_h = 16'(sh); cfg_dst_w = 16'(dw); cfg_dst_h = 16'(dh);
    cfg_step_x = 16'(sx); cfg_step_y = 16'(sy);
    start = 1'b1; out_ready = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      if (rst_at >= 0 && hs_count == rst_at) begin
        ap_rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0); chk("rst_mid_busy", busy, 0);
        chk("rst_mid_x1", out_x1, 0);       chk("rst_mid_wx0", out_wx0, 0);
        chk("rst_mid_eol", out_eol, 0);
        ap_rst_n = 1'b1;
        rst_hit = 1; timed_out = 0;
        break;
      end
      abort = (abort_at >= 0 && hs_count == abort_at && !aborted);
      if (abort) aborted = 1;
      out_ready = !(hs_count == stall_at && stall_n < stall_len);
      if (!out_ready) stall_n++;
      if (junk && hs_count == 4 && !junk_done) begin
        start = 1'b1; cfg_src_w = 16'd9; cfg_dst_w = 16'd1; cfg_step_x = 16'h0100;
        junk_done = 1;
      end else start = 1'b0;
      @(posedge ap_clk); #1;
      if (!busy) begin timed_out = 0; break; end
    end
    abort = 1'b0; start = 1'b0; out_ready = 1'b1;
    chk("timeout", timed_out, 0);
    if (aborted || rst_hit) begin
      chk("stop_valid", out_valid, 0);
      repeat (3) @(posedge ap_clk);
      #1;
      chk("stop_no_done", done_cnt, 0);
      chk("stop_busy", busy, 0);
      expq.delete();
    end else begin
      chk("beat_count", hs_count, dw * dh);
      chk("exp_left", expq.size(), 0);
      chk("done_count", done_cnt, 1);
      chk("done_latency", done_cyc - eof_cyc, 1);
    end
  endtask

  initial begin
    int x0_t2 [4] = '{0, 0, 1, 1};
    int wx1_t2[4] = '{0, 'h800, 0, 0};
    int wx0_t2[4] = '{'h1000, 'h800, 'h1000, 'h1000};
    int vbase;

    #2 ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_x0", out_x0, 0);       chk("rst_x1", out_x1, 0); chk("rst_wx0", out_wx0, 0);
    chk("rst_wy0", out_wy0, 0);     chk("rst_eol", out_eol, 0); chk("rst_eof", out_eof, 0);
    ap_rst_n = 1'b1;
    mon_en = 1'b1;

    // Identity 4x4
    run_frame(4, 4, 4, 4, 'h1000, 'h1000, -1, 0, -1, -1, 0);
    chk("t1_b5_x0", log_q[5].x0, 1);   chk("t1_b5_y0", log_q[5].y0, 1);
    chk("t1_b5_wx0", log_q[5].wx0, 'h1000); chk("t1_b5_wx1", log_q[5].wx1, 0);
    chk("t1_b3_eol", log_q[3].eol, 1); chk("t1_b2_eol", log_q[2].eol, 0);
    chk("t1_b15_eof", log_q[15].eof, 1); chk("t1_b14_eof", log_q[14].eof, 0);

    // 2x horizontal upscale
    run_frame(2, 1, 4, 1, 'h0800, 'h1000, -1, 0, -1, -1, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t2_x0", log_q[k].x0, x0_t2[k]);   chk("t2_x1", log_q[k].x1, 1);
      chk("t2_wx1", log_q[k].wx1, wx1_t2[k]); chk("t2_wx0", log_q[k].wx0, wx0_t2[k]);
    end

    // Backpressure at ox=2, plus a start and cfg change while busy
    run_frame(4, 4, 4, 4, 'h1000, 'h1000, 2, 5, -1, -1, 1);
    chk("t3_stall_cycles", stall_n, 5);
    chk("t3_b6_x0", log_q[6].x0, 2);

    // Empty destination
    vbase = valid_cnt; done_cnt = 0;
    @(posedge ap_clk); #1;
    cfg_dst_w = 16'd0; cfg_dst_h = 16'd4; start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    chk("t4_done", done, 1); chk("t4_busy", busy, 1); chk("t4_valid", out_valid, 0);
    @(posedge ap_clk); #1;
    chk("t4_done_end", done, 0); chk("t4_busy_end", busy, 0);
    chk("t4_valid_cnt", valid_cnt - vbase, 0); chk("t4_done_cnt", done_cnt, 1);

    // Abort at beat 7, restart; then reset at beat 7, restart
    run_frame(4, 4, 4, 4, 'h1000, 'h1000, -1, 0, 7, -1, 0);
    run_frame(4, 4, 4, 4, 'h1000, 'h1000, -1, 0, -1, -1, 0);
    chk("t5_b9_x0", log_q[9].x0, 1);   chk("t5_b9_y0", log_q[9].y0, 2);
    run_frame(4, 4, 4, 4, 'h1000, 'h1000, -1, 0, -1, 7, 0);
    run_frame(4, 4, 4, 4, 'h1000, 'h1000, -1, 0, -1, -1, 0);
    chk("t5r_b15_eof", log_q[15].eof, 1);

    // Large step clamps from beat 1
    run_frame(3, 1, 8, 1, 'hFFFF, 'h1000, -1, 0, -1, -1, 0);
    chk("t6_b0_x1", log_q[0].x1, 1);
    for (int k = 1; k < 8; k++) begin
      chk("t6_x0", log_q[k].x0, 2); chk("t6_x1", log_q[k].x1, 2);
      chk("t6_wx1", log_q[k].wx1, 0); chk("t6_wx0", log_q[k].wx0, 'h1000);
    end

    // Long line drives the accumulator into saturation
    run_frame('hFFFF, 1, 4200, 1, 'hFFFF, 'h1000, -1, 0, -1, -1, 0);
    chk("t6s_last_x0", log_q[4199].x0, 'hFFFE);
    chk("t6s_last_wx0", log_q[4199].wx0, 'h1000);
    chk("t6s_b1_x0", log_q[1].x0, 15); chk("t6s_b1_wx1", log_q[1].wx1, 'hFFF);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
